// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: two-requester round-robin arbiter for a single-port on-chip RAM.
// Rev 1.0 -- define MEM_ARB_FIXED_PRIO_EN for A-priority with B starvation guard.
`default_nettype none

module onchip_mem_arbiter #(
   parameter int ADDR_W       = 8,
   parameter int DATA_W       = 32,
   parameter int BE_W         = DATA_W / 8,
   parameter int RD_LATENCY   = 1,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] a_address,
   input  logic [BE_W-1:0]   a_byteenable,
   input  logic              a_read,
   input  logic              a_write,
   input  logic [DATA_W-1:0] a_writedata,
   output logic              a_waitrequest,
   output logic [DATA_W-1:0] a_readdata,
   output logic              a_readdatavalid,
   input  logic [ADDR_W-1:0] b_address,
   input  logic [BE_W-1:0]   b_byteenable,
   input  logic              b_read,
   input  logic              b_write,
   input  logic [DATA_W-1:0] b_writedata,
   output logic              b_waitrequest,
   output logic [DATA_W-1:0] b_readdata,
   output logic              b_readdatavalid,
   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   logic req_a, req_b;
   logic grant_a, grant_b;
   logic b_wins_tie;
   logic rd_issue;
   logic [RD_LATENCY-1:0] pipe_vld;
   logic [RD_LATENCY-1:0] pipe_own;   // 1 = read issued by B

   // Requests are masked during reset so nothing is granted or issued.
   assign req_a = reset_n & (a_read | a_write);
   assign req_b = reset_n & (b_read | b_write);

`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   logic [CNT_W-1:0] starve_cnt;

   assign b_wins_tie = (starve_cnt == CNT_W'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (!reset_n)
         starve_cnt <= '0;
      else if (!req_b || grant_b)
         starve_cnt <= '0;
      else if (!b_wins_tie)
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   logic last_grant;   // 1 = B was granted last

   assign b_wins_tie = ~last_grant;

   always_ff @(posedge clk) begin
      if (!reset_n)
         last_grant <= 1'b1;
      else if (grant_a || grant_b)
         last_grant <= grant_b;
   end
`endif

   assign grant_a = req_a & ~(req_b & b_wins_tie);
   assign grant_b = req_b & ~grant_a;

   assign a_waitrequest = ~grant_a;
   assign b_waitrequest = ~grant_b;

   // Idle cycles leave the A-side values on the RAM bus.
   assign mem_chipselect = grant_a | grant_b;
   assign mem_write      = (grant_a & a_write) | (grant_b & b_write);
   assign mem_address    = grant_b ? b_address    : a_address;
   assign mem_byteenable = grant_b ? b_byteenable : a_byteenable;
   assign mem_writedata  = grant_b ? b_writedata  : a_writedata;

   assign rd_issue = mem_chipselect & ~mem_write;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         pipe_vld <= '0;
         pipe_own <= '0;
      end else begin
         pipe_vld[0] <= rd_issue;
         pipe_own[0] <= grant_b;
         for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_vld[i] <= pipe_vld[i-1];
            pipe_own[i] <= pipe_own[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n)
         mem_clken <= 1'b0;
      else
         mem_clken <= 1'b1;
   end

   assign a_readdatavalid = reset_n & pipe_vld[RD_LATENCY-1] & ~pipe_own[RD_LATENCY-1];
   assign b_readdatavalid = reset_n & pipe_vld[RD_LATENCY-1] &  pipe_own[RD_LATENCY-1];
   assign a_readdata      = mem_readdata;
   assign b_readdata      = mem_readdata;

endmodule

`default_nettype wire
